// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: registered owner state and requester IDs.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CORE = 2'd1,
        ST_DBG  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_t;

    function automatic state_t owner_state(input owner_t own);
        return (own == OWN_DBG) ? ST_DBG : ST_CORE;
    endfunction

endpackage

// File: rtl/arb_burst_ctr.sv
// Saturating run-length counter for consecutive grants to the same owner.
module arb_burst_ctr #(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_load1,
    input  logic i_inc,
    output logic o_at_max
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            r_cnt <= CNT_W'(1);
        end else if (i_inc && (r_cnt != MAX_CNT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max = (r_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the core and a debug port,
// with combinational grant, same-cycle access and registered read return.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data
);

    state_t            r_state;
    state_t            w_next_state;
    owner_t            r_last_win;
    logic              w_core_req;
    logic              w_dbg_req;
    logic              w_any;
    logic              w_dbg_wins;
    logic              w_lock_hold;
    logic              w_at_max;
    logic              r_core_rvalid;
    logic              r_dbg_rvalid;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;

    // Requests are masked while reset is low so no grant or memory strobe can escape.
    assign w_core_req  = core_req & reset;
    assign w_dbg_req   = dbg_req & reset;
    assign w_any       = w_core_req | w_dbg_req;
    assign w_lock_hold = (r_state == ST_DBG) & dbg_lock & ~w_at_max;

    always_comb begin
        w_dbg_wins = w_dbg_req;
        if (w_core_req && w_dbg_req) begin
            w_dbg_wins = w_lock_hold | (r_last_win == OWN_CORE);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = ST_IDLE;
        core_gnt     = 1'b0;
        dbg_gnt      = 1'b0;
        mem_addr     = '0;
        mem_wr_data  = '0;
        mem_wr_en    = 1'b0;
        mem_rd_en    = 1'b0;
        if (w_any) begin
            w_next_state = owner_state(owner_t'(w_dbg_wins));
            if (w_dbg_wins) begin
                dbg_gnt     = 1'b1;
                mem_addr    = dbg_addr;
                mem_wr_data = dbg_wdata;
                mem_wr_en   = dbg_we;
                mem_rd_en   = ~dbg_we;
            end else begin
                core_gnt    = 1'b1;
                mem_addr    = core_addr;
                mem_wr_data = core_wdata;
                mem_wr_en   = core_we;
                mem_rd_en   = ~core_we;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_last_win <= OWN_DBG;
        end else begin
            r_state <= w_next_state;
            if (w_any) begin
                r_last_win <= owner_t'(w_dbg_wins);
            end
        end
    end

    arb_burst_ctr #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_ctr (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (~w_any),
        .i_load1  (w_any & (w_next_state != r_state)),
        .i_inc    (w_any & (w_next_state == r_state)),
        .o_at_max (w_at_max)
    );

    // NOTE: read-data registers are reset too, so a reset leaves no stale word visible to either side.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_core_rvalid <= 1'b0;
            r_core_rdata  <= '0;
            r_dbg_rvalid  <= 1'b0;
            r_dbg_rdata   <= '0;
        end else begin
            r_core_rvalid <= core_gnt & ~core_we;
            r_dbg_rvalid  <= dbg_gnt & ~dbg_we;
            if (core_gnt && !core_we) begin
                r_core_rdata <= mem_rd_data;
            end
            if (dbg_gnt && !dbg_we) begin
                r_dbg_rdata <= mem_rd_data;
            end
        end
    end

    assign core_stall  = w_core_req & ~core_gnt;
    assign core_rvalid = r_core_rvalid;
    assign core_rdata  = r_core_rdata;
    assign dbg_rvalid  = r_dbg_rvalid;
    assign dbg_rdata   = r_dbg_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, corner sequences and a random run
// compared cycle by cycle against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              preload = 1'b1;
    logic              core_req = 1'b0, core_we = 1'b0;
    logic [ADDR_W-1:0] core_addr = '0;
    logic [DATA_W-1:0] core_wdata = '0;
    logic              dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic              core_gnt, core_stall, core_rvalid;
    logic [DATA_W-1:0] core_rdata;
    logic              dbg_gnt, dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en, mem_rd_en;
    logic [DATA_W-1:0] mem_wr_data, mem_rd_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_stall  (core_stall),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_lock    (dbg_lock),
        .dbg_gnt     (dbg_gnt),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data)
    );

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return (i == 5) ? 32'h0000_1234 : (32'h5A00_0000 | (i * 32'h0001_0101));
    endfunction

    // Single-port memory: combinational read, write on the rising edge.
    logic [DATA_W-1:0] mem [DEPTH];
    assign mem_rd_data = mem[mem_addr];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
        end
    end

    // Reference model: owner 0=none 1=core 2=dbg; m_run = consecutive wins of the current owner.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                m_state, m_last, m_run;
    logic              m_cv, m_dv;
    logic [DATA_W-1:0] m_cd, m_dd;

    task automatic model_reset();
        m_state = 0; m_last = 2; m_run = 0;
        m_cv = 1'b0; m_dv = 1'b0; m_cd = '0; m_dd = '0;
    endtask

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge; drives one cycle, checks at the falling edge.
    task automatic run_cycle(input logic cr, input logic cwe, input logic [ADDR_W-1:0] ca,
                             input logic [DATA_W-1:0] cwd, input logic dr, input logic dwe,
                             input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dwd,
                             input logic dl, input string tag,
                             output logic o_cg, output logic o_dg, output logic o_st);
        int                win;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd, rd;
        core_req = cr; core_we = cwe; core_addr = ca; core_wdata = cwd;
        dbg_req = dr; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd; dbg_lock = dl;
        if (cr && dr) begin
            if (m_state == 2 && dl && m_run < MAX_BURST) win = 2;
            else win = (m_last == 2) ? 1 : 2;
        end else if (cr) win = 1;
        else if (dr) win = 2;
        else win = 0;
        e_we   = (win == 1) ? cwe : (win == 2) ? dwe : 1'b0;
        e_addr = (win == 1) ? ca : (win == 2) ? da : '0;
        e_wd   = (win == 1) ? cwd : (win == 2) ? dwd : '0;
        @(negedge clk);
        o_cg = core_gnt; o_dg = dbg_gnt; o_st = core_stall;
        check({tag, " core_gnt"}, core_gnt, win == 1);
        check({tag, " dbg_gnt"}, dbg_gnt, win == 2);
        check({tag, " core_stall"}, core_stall, cr && win != 1);
        check({tag, " mem_wr_en"}, mem_wr_en, win != 0 && e_we);
        check({tag, " mem_rd_en"}, mem_rd_en, win != 0 && !e_we);
        check({tag, " mem_addr"}, mem_addr, e_addr);
        check({tag, " mem_wr_data"}, mem_wr_data, e_wd);
        check({tag, " core_rvalid"}, core_rvalid, m_cv);
        check({tag, " core_rdata"}, core_rdata, m_cd);
        check({tag, " dbg_rvalid"}, dbg_rvalid, m_dv);
        check({tag, " dbg_rdata"}, dbg_rdata, m_dd);
        @(posedge clk);
        rd = ref_mem[e_addr];
        if (win != 0) begin
            if (e_we) ref_mem[e_addr] = e_wd;
            m_run  = (win == m_state) ? ((m_run < MAX_BURST) ? m_run + 1 : m_run) : 1;
            m_last = win;
        end else begin
            m_run = 0;
        end
        m_cv = (win == 1) && !cwe;
        m_dv = (win == 2) && !dwe;
        if (m_cv) m_cd = rd;
        if (m_dv) m_dd = rd;
        m_state = win;
        #1;
    endtask

    typedef struct {
        logic cr, dr, dl;
        logic cg, dg, st;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        vec_t              tbl[$];
        logic              cg, dg, st;
        logic              c_pend, c_we, d_pend, d_we, lock;
        logic [ADDR_W-1:0] c_addr, d_addr;
        logic [DATA_W-1:0] c_wd, d_wd;

        // Contention after reset, locked burst, idle gap: {cr,dr,dl} -> {core_gnt,dbg_gnt,core_stall}
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        model_reset();
        repeat (3) @(posedge clk);
        preload = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Core-only load of the preloaded word at address 5
        run_cycle(1'b1, 1'b0, 5'd5, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "core_load", cg, dg, st);
        check("core_load gnt", cg, 1'b1);
        check("core_load stall", st, 1'b0);
        check("core_load rvalid", core_rvalid, 1'b1);
        check("core_load rdata", core_rdata, 32'h0000_1234);

        // Reset asserted during a core store: everything quiet, no write lands
        core_req = 1'b1; core_we = 1'b1; core_addr = 5'd3; core_wdata = 32'hAA;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'hBB;
        reset = 1'b0;
        @(negedge clk);
        check("rst core_gnt", core_gnt, 1'b0);
        check("rst dbg_gnt", dbg_gnt, 1'b0);
        check("rst core_stall", core_stall, 1'b0);
        check("rst mem_wr_en", mem_wr_en, 1'b0);
        check("rst mem_rd_en", mem_rd_en, 1'b0);
        check("rst mem_addr", mem_addr, '0);
        check("rst mem_wr_data", mem_wr_data, '0);
        check("rst core_rvalid", core_rvalid, 1'b0);
        check("rst core_rdata", core_rdata, '0);
        check("rst dbg_rvalid", dbg_rvalid, 1'b0);
        check("rst dbg_rdata", dbg_rdata, '0);
        @(posedge clk);
        #1;
        core_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("rst no write mem3", mem[3], init_word(3));
        check("rst no write mem4", mem[4], init_word(4));

        // Directed arbitration table
        foreach (tbl[i]) begin
            run_cycle(tbl[i].cr, 1'b0, 5'($urandom), $urandom, tbl[i].dr, 1'($urandom),
                      5'($urandom), $urandom, tbl[i].dl, $sformatf("tbl%0d", i), cg, dg, st);
            check($sformatf("tbl%0d exp core_gnt", i), cg, tbl[i].cg);
            check($sformatf("tbl%0d exp dbg_gnt", i), dg, tbl[i].dg);
            check($sformatf("tbl%0d exp core_stall", i), st, tbl[i].st);
        end

        // Debug store then core load of the same word on the next grant
        run_cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd7, 32'hDEAD, 1'b0, "b2b_st", cg, dg, st);
        check("b2b_st dbg_gnt", dg, 1'b1);
        run_cycle(1'b1, 1'b0, 5'd7, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "b2b_ld", cg, dg, st);
        check("b2b_ld core_gnt", cg, 1'b1);
        check("b2b_ld core_rdata", core_rdata, 32'hDEAD);
        check("b2b_ld core_rvalid", core_rvalid, 1'b1);

        // Random traffic; each requester holds its request until granted
        c_pend = 1'b0; d_pend = 1'b0;
        c_we = 1'b0; d_we = 1'b0; c_addr = '0; d_addr = '0; c_wd = '0; d_wd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!c_pend && $urandom_range(0, 99) < 65) begin
                c_pend = 1'b1; c_we = 1'($urandom); c_addr = 5'($urandom_range(0, 7)); c_wd = $urandom;
            end
            if (!d_pend && $urandom_range(0, 99) < 65) begin
                d_pend = 1'b1; d_we = 1'($urandom); d_addr = 5'($urandom_range(0, 7)); d_wd = $urandom;
            end
            lock = ($urandom_range(0, 99) < 70);
            run_cycle(c_pend, c_we, c_addr, c_wd, d_pend, d_we, d_addr, d_wd, lock,
                      $sformatf("rnd%0d", n), cg, dg, st);
            if (cg) c_pend = 1'b0;
            if (dg) d_pend = 1'b0;
        end
        run_cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "drain", cg, dg, st);

        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
